i2c_fifo_write_engine: RTL and testbench
========================================

Name: i2c_fifo_write_engine

Overview:
- I2C master write engine on the read side of the TX FIFO.
- Drains bytes from the FIFO read port and sends them MSB-first on open-drain SCL/SDA.
- The first byte popped is the slave address + W bit; no special handling.
- Frames each burst with START/STOP, checks the slave ACK after every byte, and aborts on NACK.

Parameters:
DATA_SIZE, 8, width of a FIFO word and of an I2C byte
CLK_DIV, 4, read_clk cycles per SCL quarter-period (≥2); SCL period = 4*CLK_DIV cycles

Ports:
read_clk  input  1  block clock (same clock as the FIFO read side)
read_reset_n  input  1  asynchronous active-low reset
enable  input  1  request to start a write burst; sampled only in IDLE
read_data  input  DATA_SIZE  FIFO head word; valid whenever read_empty=0
read_empty  input  1  FIFO empty flag
read_increment  output  1  one-cycle FIFO pop strobe
sda_in  input  1  sampled SDA line
scl_out  output  1  SCL drive: 0 = pull low, 1 = release
sda_out  output  1  SDA drive: 0 = pull low, 1 = release
busy  output  1  high from START to end of STOP
byte_done  output  1  one-cycle pulse per byte ACKed by the slave
ack_error  output  1  sticky NACK flag; cleared when the next burst is accepted

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - scl_out=1, sda_out=1, busy=0, read_increment=0, byte_done=0, ack_error=0.
  - Quarter counter and bit counter cleared.
  - Mid-transfer reset abandons the burst with no STOP generated.
- Timing base:
  - Quarter counter counts 0..CLK_DIV-1; quarter index q0..q3 advances on counter wrap.
  - Every bit slot is q0..q3: SCL=0 in q0 and q3, SCL=1 in q1 and q2.
  - SDA changes only at the first cycle of q0.
- IDLE:
  - scl_out=1, sda_out=1.
  - If enable=1 and read_empty=0: clear ack_error, set busy, go to START.
  - enable with read_empty=1 is ignored. enable outside IDLE is ignored.
- START (one slot): q0–q1 SCL=1, SDA=1; q2–q3 SCL=1, SDA=0. Then go to LOAD.
- LOAD (exactly 1 cycle, SCL=0, SDA held):
  - If read_empty=0: shift_reg<=read_data, assert read_increment this cycle, bit_cnt<=DATA_SIZE-1, go to SEND.
  - If read_empty=1: go to STOP.
- SEND (DATA_SIZE slots):
  - sda_out=shift_reg MSB for the whole slot.
  - At the end of q3: shift left, decrement bit_cnt. Go to ACK after the slot with bit_cnt=0.
- ACK (one slot):
  - sda_out=1 (released).
  - sda_in sampled on the first cycle of q2.
  - At the end of q3:
    - sample=0: pulse byte_done, go to LOAD.
    - sample=1: ack_error<=1, go to STOP.
- STOP (one slot): q0 SCL=0, SDA=0; q1–q2 SCL=1, SDA=0; q3 SCL=1, SDA=1. Then go to IDLE with busy=0.
- FIFO rules:
  - read_increment asserts only in LOAD with read_empty=0, so the block never pops an empty FIFO.
  - Bytes written to the FIFO during a burst are sent in the same burst if they are present when LOAD executes.
- Per-byte cost: 1 + 9*4*CLK_DIV cycles.
- Not supported (SCL held at the driven value): clock stretching, arbitration loss, repeated START, reads.

Test Plan:
1. DATA_SIZE=8, CLK_DIV=4. FIFO holds 0xA5, slave ACKs. Pulse enable → busy high for 178 cycles (START 16 + LOAD 1 + 128 + ACK 16 + LOAD 1 + STOP 16). SDA at each SCL rise = 1,0,1,0,0,1,0,1. Exactly one read_increment. One byte_done. ack_error=0. Bus ends with SCL=1, SDA=1.
2. FIFO holds 0x50, 0x3C, 0xFF, all ACKed → three read_increment pulses, each one cycle in LOAD. Three byte_done pulses. Bytes appear in order on SDA. A single START and a single STOP.
3. FIFO holds 0x50, 0x11; slave NACKs the first byte → ack_error=1 after the first ACK slot. STOP follows immediately. Only one pop; 0x11 stays in the FIFO. A next enable clears ack_error.
4. enable with read_empty=1 → no state change: busy=0, SCL=SDA=1, no pop. enable pulsed while busy → ignored, burst unchanged.
5. Assert read_reset_n=0 in the middle of bit 3 of a byte → scl_out, sda_out, busy, byte_done and read_increment are at reset values immediately (asynchronously). After release, a new enable starts a clean START.
6. FIFO empty mid-burst, then a word written during the ACK slot of byte 1 → the word is popped in the following LOAD and sent without a STOP between bytes.

Source files
------------

// File: rtl/i2c_fifo_write_engine.sv
// I2C master write engine: pops bytes from the TX FIFO read port and shifts them out
// MSB-first on open-drain SCL/SDA, framed by START/STOP with per-byte ACK checking.
module i2c_fifo_write_engine #(
    parameter int DATA_SIZE = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                 read_clk,
    input  logic                 read_reset_n,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] read_data,
    input  logic                 read_empty,
    output logic                 read_increment,
    input  logic                 sda_in,
    output logic                 scl_out,
    output logic                 sda_out,
    output logic                 busy,
    output logic                 byte_done,
    output logic                 ack_error
);

    localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {IDLE, START, LOAD, SEND, ACK, STOP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [QW-1:0]        qcnt;
    logic [1:0]           quarter;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_SIZE-1:0] shift_reg;
    logic                 ack_sample;
    logic                 sda_last;
    logic                 timing_on;
    logic                 q_wrap;
    logic                 slot_end;
    logic                 q2_first;
    logic                 accept;
    logic                 load_pop;

    // LOAD is a single cycle outside the slot timing, so the quarter counter idles there
    assign timing_on = (state == START) || (state == SEND) || (state == ACK) || (state == STOP);
    assign q_wrap    = (qcnt == QMAX);
    assign slot_end  = q_wrap && (quarter == 2'd3);
    assign q2_first  = (quarter == 2'd2) && (qcnt == '0);
    assign accept    = (state == IDLE) && enable && !read_empty;
    assign load_pop  = (state == LOAD) && !read_empty;

    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        scl_out        = 1'b1;
        sda_out        = 1'b1;
        read_increment = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable && !read_empty) state_nxt = START;
            end
            START: begin
                sda_out = (quarter < 2'd2);
                if (slot_end) state_nxt = LOAD;
            end
            LOAD: begin
                scl_out = 1'b0;
                sda_out = sda_last;
                if (!read_empty) begin
                    read_increment = 1'b1;
                    state_nxt      = SEND;
                end else begin
                    state_nxt = STOP;
                end
            end
            SEND: begin
                scl_out = quarter[0] ^ quarter[1];
                sda_out = shift_reg[DATA_SIZE-1];
                if (slot_end && (bit_cnt == '0)) state_nxt = ACK;
            end
            ACK: begin
                scl_out = quarter[0] ^ quarter[1];
                if (slot_end) state_nxt = ack_sample ? STOP : LOAD;
            end
            STOP: begin
                scl_out = (quarter != 2'd0);
                sda_out = (quarter == 2'd3);
                if (slot_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            qcnt       <= '0;
            quarter    <= 2'd0;
            bit_cnt    <= '0;
            ack_error  <= 1'b0;
            byte_done  <= 1'b0;
            ack_sample <= 1'b0;
            sda_last   <= 1'b1;
        end else begin
            if (!timing_on) begin
                qcnt    <= '0;
                quarter <= 2'd0;
            end else begin
                qcnt <= q_wrap ? '0 : qcnt + 1'b1;
                if (q_wrap) quarter <= quarter + 2'd1;
            end
            if (load_pop) begin
                bit_cnt <= BMAX;
            end else if ((state == SEND) && slot_end) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if ((state == ACK) && q2_first) ack_sample <= sda_in;
            if (accept) begin
                ack_error <= 1'b0;
            end else if ((state == ACK) && slot_end && ack_sample) begin
                ack_error <= 1'b1;
            end
            byte_done <= (state == ACK) && slot_end && !ack_sample;
            // LOAD re-drives whatever SDA level the previous cycle ended with
            sda_last  <= sda_out;
        end
    end

    always_ff @(posedge read_clk) begin
        if (load_pop) begin
            shift_reg <= read_data;
        end else if ((state == SEND) && slot_end) begin
            shift_reg <= shift_reg << 1;
        end
    end

endmodule

// File: tb/tb_i2c_fifo_write_engine.sv
// Directed bench for i2c_fifo_write_engine: FIFO model, ACKing slave and bus monitor.
module tb_i2c_fifo_write_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] read_data;
    logic       read_empty;
    logic       read_increment;
    logic       sda_in;
    logic       scl_out;
    logic       sda_out;
    logic       busy;
    logic       byte_done;
    logic       ack_error;
    logic       sda_line;

    always #5 clk = ~clk;

    i2c_fifo_write_engine #(.DATA_SIZE(8), .CLK_DIV(4)) dut (
        .read_clk      (clk),
        .read_reset_n  (rst_n),
        .enable        (enable),
        .read_data     (read_data),
        .read_empty    (read_empty),
        .read_increment(read_increment),
        .sda_in        (sda_in),
        .scl_out       (scl_out),
        .sda_out       (sda_out),
        .busy          (busy),
        .byte_done     (byte_done),
        .ack_error     (ack_error)
    );

    // FIFO model
    logic [7:0] fifo_mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign read_data  = fifo_mem[rd_ptr[3:0]];
    assign read_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) if (read_increment) rd_ptr <= rd_ptr + 1;

    // Open-drain bus with slave pulling SDA low for ACK
    logic slave_low = 1'b0;
    int   nack_sel  = -1;
    assign sda_line = sda_out & ~slave_low;
    assign sda_in   = sda_line;

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         rise_n = 0;
    int         byte_idx = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] rx_mem [0:63];
    int         rx_cnt = 0;
    int         pops = 0, dones = 0, busy_cyc = 0, starts = 0, stops = 0;

    always @(negedge clk) begin
        prev_scl <= scl_out;
        prev_sda <= sda_line;
        if (read_increment) pops <= pops + 1;
        if (byte_done) dones <= dones + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (scl_out && prev_scl && !prev_sda && sda_line) stops <= stops + 1;
        if (scl_out && prev_scl && prev_sda && !sda_line) begin
            starts   <= starts + 1;
            rise_n   <= 0;
            byte_idx <= 0;
        end else if (scl_out && !prev_scl) begin
            rise_n <= rise_n + 1;
            if ((rise_n + 1) % 9 != 0) begin
                cur <= {cur[6:0], sda_line};
                if ((rise_n + 1) % 9 == 8) begin
                    rx_mem[rx_cnt[5:0]] <= {cur[6:0], sda_line};
                    rx_cnt <= rx_cnt + 1;
                end
            end else begin
                byte_idx <= byte_idx + 1;
            end
        end else if (!scl_out && prev_scl && rise_n > 0) begin
            if (rise_n % 9 == 8) slave_low <= (byte_idx != nack_sel);
            else if (rise_n % 9 == 0) slave_low <= 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    task automatic start_burst();
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    int b0, p0, d0, s0, t0, r0;
    task automatic snap();
        b0 = busy_cyc; p0 = pops; d0 = dones; s0 = starts; t0 = stops; r0 = rx_cnt;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl",  {31'd0, scl_out}, 32'd1);
        check("rst_sda",  {31'd0, sda_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pop",  {31'd0, read_increment}, 32'd0);
        check("rst_done", {31'd0, byte_done}, 32'd0);
        check("rst_aerr", {31'd0, ack_error}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte, ACKed
        push(8'hA5);
        snap();
        start_burst();
        wait_idle("t1");
        check("t1_busy_cycles", busy_cyc - b0, 32'd178);
        check("t1_pops",   pops - p0, 32'd1);
        check("t1_dones",  dones - d0, 32'd1);
        check("t1_bytes",  rx_cnt - r0, 32'd1);
        check("t1_byte0",  {24'd0, rx_mem[r0]}, 32'hA5);
        check("t1_starts", starts - s0, 32'd1);
        check("t1_stops",  stops - t0, 32'd1);
        check("t1_aerr",   {31'd0, ack_error}, 32'd0);
        check("t1_bus",    {30'd0, scl_out, sda_out}, 32'd3);

        // three bytes in one burst
        push(8'h50); push(8'h3C); push(8'hFF);
        snap();
        start_burst();
        wait_idle("t2");
        check("t2_busy_cycles", busy_cyc - b0, 32'd468);
        check("t2_pops",   pops - p0, 32'd3);
        check("t2_dones",  dones - d0, 32'd3);
        check("t2_byte0",  {24'd0, rx_mem[r0]}, 32'h50);
        check("t2_byte1",  {24'd0, rx_mem[r0+1]}, 32'h3C);
        check("t2_byte2",  {24'd0, rx_mem[r0+2]}, 32'hFF);
        check("t2_starts", starts - s0, 32'd1);
        check("t2_stops",  stops - t0, 32'd1);

        // NACK on first byte
        nack_sel = 0;
        push(8'h50); push(8'h11);
        snap();
        start_burst();
        wait_idle("t3");
        check("t3_busy_cycles", busy_cyc - b0, 32'd177);
        check("t3_aerr",   {31'd0, ack_error}, 32'd1);
        check("t3_pops",   pops - p0, 32'd1);
        check("t3_dones",  dones - d0, 32'd0);
        check("t3_left",   wr_ptr - rd_ptr, 32'd1);
        check("t3_stops",  stops - t0, 32'd1);
        nack_sel = -1;
        snap();
        start_burst();
        check("t3_aerr_clr", {31'd0, ack_error}, 32'd0);
        wait_idle("t3b");
        check("t3b_byte",  {24'd0, rx_mem[r0]}, 32'h11);
        check("t3b_aerr",  {31'd0, ack_error}, 32'd0);
        check("t3b_dones", dones - d0, 32'd1);

        // enable with empty FIFO, then enable while busy
        snap();
        start_burst();
        repeat (5) @(negedge clk);
        check("t4_busy",  {31'd0, busy}, 32'd0);
        check("t4_bus",   {30'd0, scl_out, sda_out}, 32'd3);
        check("t4_pops",  pops - p0, 32'd0);
        push(8'h96);
        snap();
        start_burst();
        repeat (40) @(negedge clk);
        start_burst();
        wait_idle("t4b");
        check("t4b_busy_cycles", busy_cyc - b0, 32'd178);
        check("t4b_pops",   pops - p0, 32'd1);
        check("t4b_byte",   {24'd0, rx_mem[r0]}, 32'h96);
        check("t4b_starts", starts - s0, 32'd1);

        // asynchronous reset in the middle of bit 3
        push(8'hC3);
        start_burst();
        repeat (72) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_scl",  {31'd0, scl_out}, 32'd1);
        check("t5_sda",  {31'd0, sda_out}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, byte_done}, 32'd0);
        check("t5_pop",  {31'd0, read_increment}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h5A);
        snap();
        start_burst();
        wait_idle("t5b");
        check("t5b_busy_cycles", busy_cyc - b0, 32'd178);
        check("t5b_starts", starts - s0, 32'd1);
        check("t5b_byte",   {24'd0, rx_mem[r0]}, 32'h5A);

        // word arrives during the ACK slot of byte 1
        push(8'h81);
        snap();
        start_burst();
        repeat (148) @(negedge clk);
        push(8'h7E);
        wait_idle("t6");
        check("t6_busy_cycles", busy_cyc - b0, 32'd323);
        check("t6_pops",   pops - p0, 32'd2);
        check("t6_byte0",  {24'd0, rx_mem[r0]}, 32'h81);
        check("t6_byte1",  {24'd0, rx_mem[r0+1]}, 32'h7E);
        check("t6_starts", starts - s0, 32'd1);
        check("t6_stops",  stops - t0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
